// File: rtl/switch_event_encoder_pkg.sv
// Shared types and constants for the switch event encoder: event kinds,
// code width / event field helpers and reset levels.
package switch_event_pkg;

  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_e;

  localparam logic RST_LEVEL = 1'b0;

  // Width of a 1-based switch code where 0 means "no switch".
  function automatic int code_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  // The release flag sits just above the code field.
  function automatic int is_rel_bit(input int n_ch);
    return code_width(n_ch);
  endfunction

endpackage

// File: rtl/switch_event_encoder_debounce_cell.sv
// One switch channel: 2-flop synchroniser, sample history and debounced level.
// press_stb/release_stb pulse combinationally on the tick that changes sw_state.
module switch_debounce_cell
  import switch_event_pkg::*;
#(
  parameter int STABLE_N = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  input  logic tick,
  output logic sw_state,
  output logic press_stb,
  output logic release_stb
);

  logic                sync1_r;
  logic                sync2_r;
  logic [STABLE_N-1:0] hist_r;
  logic [STABLE_N-1:0] hist_next_s;
  logic                state_r;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RST_LEVEL;
      sync2_r <= RST_LEVEL;
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // The window is judged on the history including the sample taken this tick.
  always_comb begin
    hist_next_s = {hist_r[STABLE_N-2:0], sync2_r};
    press_stb   = 1'b0;
    release_stb = 1'b0;
    if (tick && (&hist_next_s) && !state_r) begin
      press_stb = 1'b1;
    end else if (tick && !(|hist_next_s) && state_r) begin
      release_stb = 1'b1;
    end else begin
      press_stb   = 1'b0;
      release_stb = 1'b0;
    end
  end

  // Sample history and debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= {STABLE_N{RST_LEVEL}};
      state_r <= RST_LEVEL;
    end else begin
      if (tick) begin
        hist_r <= hist_next_s;
      end
      if (press_stb) begin
        state_r <= 1'b1;
      end else if (release_stb) begin
        state_r <= 1'b0;
      end
    end
  end

  assign sw_state = state_r;

endmodule

// File: rtl/switch_event_encoder.sv
// Multi-channel switch debouncer with held press code and event FIFO.
// Macro SWITCH_RELEASE_EVT_EN: when defined, releases are also queued as events.
module switch_event_encoder
  import switch_event_pkg::*;
#(
  parameter int  N_CH       = 7,
  parameter int  DIV_COUNT  = 100000,
  parameter int  STABLE_N   = 6,
  parameter int  FIFO_DEPTH = 4,
  localparam int CODE_W     = code_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sw_in,
  output logic [N_CH-1:0]   sw_state,
  output logic [CODE_W-1:0] sw_code,
  output logic              evt_valid,
  output logic [CODE_W:0]   evt_data,
  input  logic              evt_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int CNT_W      = $clog2(DIV_COUNT);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int IS_REL_BIT = is_rel_bit(N_CH);

  logic [CNT_W-1:0]  pre_cnt_r;
  logic              tick_s;
  logic [N_CH-1:0]   press_stb_s, rel_stb_s;
  logic [N_CH-1:0]   press_pend_r, rel_pend_r;
  logic [N_CH-1:0]   press_clr_s, rel_clr_s;
  logic              srv_valid_s;
  evt_kind_e         srv_kind_s;
  logic [CODE_W-1:0] srv_code_s;
  logic [CODE_W:0]   evt_word_s;
  logic [CODE_W-1:0] sw_code_r, code_next_s;
  logic [CODE_W:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [PTR_W:0]    cnt_r, cnt_next_s;
  logic              pop_s, full_s, push_acc_s, drop_s;
  logic [CODE_W:0]   head_next_s;
  logic              evt_valid_r;
  logic [CODE_W:0]   evt_data_r;
  logic              ovf_r;

  assign tick_s = (pre_cnt_r == CNT_W'(DIV_COUNT - 1));

  // Sample-tick prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    switch_debounce_cell #(
      .STABLE_N   (STABLE_N)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_in[g]),
      .tick       (tick_s),
      .sw_state   (sw_state[g]),
      .press_stb  (press_stb_s[g]),
      .release_stb(rel_stb_s[g])
    );
  end

  // Pick the lowest pending channel; press wins over release on the same channel.
  always_comb begin
    srv_valid_s = 1'b0;
    srv_kind_s  = EVT_PRESS;
    srv_code_s  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_pend_r[i] || rel_pend_r[i]) begin
        srv_valid_s = 1'b1;
        srv_code_s  = CODE_W'(i + 1);
        srv_kind_s  = press_pend_r[i] ? EVT_PRESS : EVT_RELEASE;
      end else begin
        srv_valid_s = srv_valid_s;
      end
    end
  end

  // Clear masks for the served pending bit and the event word to push.
  always_comb begin
    press_clr_s = '0;
    rel_clr_s   = '0;
    evt_word_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      press_clr_s[i] = srv_valid_s && (srv_kind_s == EVT_PRESS) && (srv_code_s == CODE_W'(i + 1));
      rel_clr_s[i]   = srv_valid_s && (srv_kind_s == EVT_RELEASE) && (srv_code_s == CODE_W'(i + 1));
    end
    evt_word_s[CODE_W-1:0] = srv_code_s;
`ifdef SWITCH_RELEASE_EVT_EN
    evt_word_s[IS_REL_BIT] = (srv_kind_s == EVT_RELEASE);
`else
    evt_word_s[IS_REL_BIT] = 1'b0;
`endif
  end

  // Pending bits: set by debounced edges, cleared when served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend_r <= '0;
      rel_pend_r   <= '0;
    end else begin
      press_pend_r <= (press_pend_r & ~press_clr_s) | press_stb_s;
`ifdef SWITCH_RELEASE_EVT_EN
      rel_pend_r   <= (rel_pend_r & ~rel_clr_s) | rel_stb_s;
`else
      rel_pend_r   <= rel_pend_r & ~rel_clr_s;
`endif
    end
  end

  // Held press code; without release events the clear comes straight from the strobe.
  always_comb begin
    code_next_s = sw_code_r;
`ifndef SWITCH_RELEASE_EVT_EN
    for (int i = 0; i < N_CH; i++) begin
      if (rel_stb_s[i] && (sw_code_r == CODE_W'(i + 1))) begin
        code_next_s = '0;
      end else begin
        code_next_s = code_next_s;
      end
    end
`endif
    if (srv_valid_s && (srv_kind_s == EVT_PRESS)) begin
      code_next_s = srv_code_s;
    end else if (srv_valid_s && (sw_code_r == srv_code_s)) begin
      code_next_s = '0;
    end else begin
      code_next_s = code_next_s;
    end
  end

  // Held press code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_code_r <= '0;
    end else begin
      sw_code_r <= code_next_s;
    end
  end

  assign pop_s      = (cnt_r != '0) && evt_ready;
  assign full_s     = (cnt_r == (PTR_W + 1)'(FIFO_DEPTH));
  assign push_acc_s = srv_valid_s && (!full_s || pop_s);
  assign drop_s     = srv_valid_s && full_s && !pop_s;

  // Next occupancy and next head, so evt_valid/evt_data can be registered.
  always_comb begin
    cnt_next_s  = cnt_r + (PTR_W + 1)'(push_acc_s) - (PTR_W + 1)'(pop_s);
    rd_next_s   = rd_ptr_r + PTR_W'(pop_s);
    head_next_s = '0;
    if (cnt_next_s == '0) begin
      head_next_s = '0;
    end else if ((cnt_r - (PTR_W + 1)'(pop_s)) == '0) begin
      head_next_s = evt_word_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Event FIFO storage, pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      evt_valid_r <= 1'b0;
      evt_data_r  <= '0;
    end else begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= evt_word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r    <= rd_next_s;
      cnt_r       <= cnt_next_s;
      evt_valid_r <= (cnt_next_s != '0);
      evt_data_r  <= head_next_s;
    end
  end

  // Sticky overflow; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= RST_LEVEL;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign sw_code   = sw_code_r;
  assign evt_valid = evt_valid_r;
  assign evt_data  = evt_data_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_switch_event_encoder.sv
// Self-checking bench for switch_event_encoder against a run-length/queue reference model.
module tb_switch_event_encoder;

  localparam int N_CH       = 7;
  localparam int DIV_COUNT  = 4;
  localparam int STABLE_N   = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int CODE_W     = 3;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   sw_in;
  logic [N_CH-1:0]   sw_state;
  logic [CODE_W-1:0] sw_code;
  logic              evt_valid;
  logic [CODE_W:0]   evt_data;
  logic              evt_ready;
  logic              ovf;
  logic              ovf_clr;

  int n_pass;
  int n_total;

  switch_event_encoder #(
    .N_CH      (N_CH),
    .DIV_COUNT (DIV_COUNT),
    .STABLE_N  (STABLE_N),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .sw_state (sw_state),
    .sw_code  (sw_code),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_ready(evt_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel run length of equal samples, pending flags, event queue.
  int              m_pre;
  bit              m_s1 [N_CH];
  bit              m_s2 [N_CH];
  bit              m_run_val [N_CH];
  int              m_run_len [N_CH];
  bit              m_state [N_CH];
  bit              m_ppend [N_CH];
  bit              m_rpend [N_CH];
  int              m_code;
  bit              m_ovf;
  logic [CODE_W:0] m_q [$];

  task automatic model_reset();
    m_pre = 0; m_code = 0; m_ovf = 0;
    m_q.delete();
    for (int i = 0; i < N_CH; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_run_val[i] = 0; m_run_len[i] = STABLE_N;
      m_state[i] = 0; m_ppend[i] = 0; m_rpend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tick; bit pstb [N_CH]; bit rstb [N_CH];
    int srv; bit srv_rel; bit room;
    tick = (m_pre == DIV_COUNT - 1);
    for (int i = 0; i < N_CH; i++) begin
      pstb[i] = 0; rstb[i] = 0;
      if (tick) begin
        if (m_s2[i] == m_run_val[i]) begin
          if (m_run_len[i] < STABLE_N) m_run_len[i]++;
        end else begin
          m_run_val[i] = m_s2[i]; m_run_len[i] = 1;
        end
        if (m_run_len[i] == STABLE_N && m_run_val[i] != m_state[i]) begin
          if (m_run_val[i]) pstb[i] = 1; else rstb[i] = 1;
        end
      end
    end
    srv = -1; srv_rel = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (srv < 0) begin
        if (m_ppend[i]) srv = i;
        else if (m_rpend[i]) begin srv = i; srv_rel = 1; end
      end
    end
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    room = (m_q.size() < FIFO_DEPTH);
    if (srv >= 0 && !room) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (srv >= 0 && room) m_q.push_back({srv_rel, CODE_W'(srv + 1)});
`ifndef SWITCH_RELEASE_EVT_EN
    for (int i = 0; i < N_CH; i++) if (rstb[i] && m_code == i + 1) m_code = 0;
`endif
    if (srv >= 0) begin
      if (!srv_rel) m_code = srv + 1;
      else if (m_code == srv + 1) m_code = 0;
      if (srv_rel) m_rpend[srv] = 0; else m_ppend[srv] = 0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (pstb[i]) begin m_ppend[i] = 1; m_state[i] = 1; end
      if (rstb[i]) begin
`ifdef SWITCH_RELEASE_EVT_EN
        m_rpend[i] = 1;
`endif
        m_state[i] = 0;
      end
      m_s2[i] = m_s1[i]; m_s1[i] = sw_in[i];
    end
    m_pre = tick ? 0 : m_pre + 1;
  endtask

  function automatic logic [N_CH-1:0] m_state_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_state[i];
    return v;
  endfunction

  function automatic logic [CODE_W:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  // One clock: advance the model with the current inputs, then sample after the edge.
  task automatic cyc();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N_CH-1:0] sw0);
    rst_n = 1'b0; sw_in = sw0; evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(7'h7F);
    n_total++; if (sw_state !== 7'h00) $display("FAIL reset_sw_state: got %h want 00", sw_state); else n_pass++;
    n_total++; if (sw_code !== 3'd0) $display("FAIL reset_sw_code: got %0d want 0", sw_code); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 4'h0) $display("FAIL reset_evt_data: got %h want 0", evt_data); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    for (int k = 0; k < 23; k++) cyc();
    n_total++; if (sw_state !== 7'h00) $display("FAIL burst_early_state: got %h want 00", sw_state); else n_pass++;
    cyc();
    n_total++; if (sw_state !== 7'h7F) $display("FAIL burst_state: got %h want 7f", sw_state); else n_pass++;
    for (int k = 0; k < 10; k++) cyc();
    n_total++; if (ovf !== 1'b1) $display("FAIL burst_ovf: got %b want 1", ovf); else n_pass++;
    n_total++; if (sw_code !== 3'd7) $display("FAIL burst_code: got %0d want 7", sw_code); else n_pass++;
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (evt_valid !== 1'b1 || evt_data !== 4'(k + 1))
        $display("FAIL burst_evt%0d: got v=%b d=%h want v=1 d=%h", k, evt_valid, evt_data, 4'(k + 1));
      else n_pass++;
      cyc();
    end
    evt_ready = 1'b0;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL burst_drained: got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset(7'h00);
    sw_in = 7'h04;
    for (int k = 0; k < 20; k++) cyc();
    sw_in = 7'h00;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n_total++; if (sw_state[2] !== 1'b0) $display("FAIL glitch_state: got %b want 0", sw_state[2]); else n_pass++;
    end
    n_total++; if (evt_valid !== 1'b0) $display("FAIL glitch_evt: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (sw_code !== 3'd0) $display("FAIL glitch_code: got %0d want 0", sw_code); else n_pass++;
  endtask

  task automatic test_press_release();
    int k;
    do_reset(7'h00);
    sw_in = 7'h04;
    for (k = 0; k < 60 && !m_state[2]; k++) cyc();
    n_total++; if (sw_state[2] !== 1'b1 || k >= 60) $display("FAIL pr_state: got %b want 1", sw_state[2]); else n_pass++;
    n_total++; if (sw_code !== 3'd0) $display("FAIL pr_code_early: got %0d want 0", sw_code); else n_pass++;
    cyc();
    n_total++; if (sw_code !== 3'd3) $display("FAIL pr_code: got %0d want 3", sw_code); else n_pass++;
    n_total++; if (evt_valid !== 1'b1 || evt_data !== 4'h3) $display("FAIL pr_evt: got v=%b d=%h want v=1 d=3", evt_valid, evt_data); else n_pass++;
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
    sw_in = 7'h00;
    for (k = 0; k < 60 && m_state[2]; k++) cyc();
    n_total++; if (sw_state[2] !== 1'b0 || k >= 60) $display("FAIL pr_release_state: got %b want 0", sw_state[2]); else n_pass++;
    cyc(); cyc();
    n_total++; if (sw_code !== 3'd0) $display("FAIL pr_release_code: got %0d want 0", sw_code); else n_pass++;
`ifdef SWITCH_RELEASE_EVT_EN
    n_total++; if (evt_valid !== 1'b1 || evt_data !== 4'hB) $display("FAIL pr_release_evt: got v=%b d=%h want v=1 d=b", evt_valid, evt_data); else n_pass++;
`else
    n_total++; if (evt_valid !== 1'b0) $display("FAIL pr_release_evt: got v=%b want v=0", evt_valid); else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    int k;
    do_reset(7'h00);
    sw_in = 7'h21;
    for (k = 0; k < 60 && !m_state[0]; k++) cyc();
    n_total++; if (sw_state !== 7'h21) $display("FAIL sim_state: got %h want 21", sw_state); else n_pass++;
    cyc();
    n_total++; if (evt_data !== 4'h1 || sw_code !== 3'd1) $display("FAIL sim_first: got d=%h c=%0d want d=1 c=1", evt_data, sw_code); else n_pass++;
    cyc();
    n_total++; if (sw_code !== 3'd6) $display("FAIL sim_code: got %0d want 6", sw_code); else n_pass++;
    evt_ready = 1'b1; cyc();
    n_total++; if (evt_valid !== 1'b1 || evt_data !== 4'h6) $display("FAIL sim_second: got v=%b d=%h want v=1 d=6", evt_valid, evt_data); else n_pass++;
    cyc(); evt_ready = 1'b0;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL sim_empty: got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    int k; int n;
    do_reset(7'h00);
    sw_in = 7'h0F;
    for (k = 0; k < 60 && !m_state[0]; k++) cyc();
    for (k = 0; k < 6; k++) cyc();
    sw_in = 7'h1F;
    for (k = 0; k < 60 && !m_ppend[4]; k++) cyc();
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
    n_total++; if (ovf !== 1'b0) $display("FAIL full_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (evt_valid !== 1'b1 || evt_data !== 4'h2) $display("FAIL full_head: got v=%b d=%h want v=1 d=2", evt_valid, evt_data); else n_pass++;
    n = 0; evt_ready = 1'b1;
    for (k = 0; k < 8 && evt_valid; k++) begin
      n_total++; if (evt_data !== 4'(k + 2)) $display("FAIL full_drain%0d: got %h want %h", k, evt_data, 4'(k + 2)); else n_pass++;
      n++; cyc();
    end
    evt_ready = 1'b0;
    n_total++; if (n !== 4) $display("FAIL full_occupancy: got %0d want 4", n); else n_pass++;
  endtask

  task automatic test_release_ch6();
    int k; int n;
    do_reset(7'h00);
    sw_in = 7'h40;
    for (k = 0; k < 60 && !m_state[6]; k++) cyc();
    cyc();
    n_total++; if (sw_code !== 3'd7) $display("FAIL ch6_code_press: got %0d want 7", sw_code); else n_pass++;
    sw_in = 7'h00;
    for (k = 0; k < 60 && m_state[6]; k++) cyc();
    cyc(); cyc();
    n_total++; if (sw_code !== 3'd0) $display("FAIL ch6_code_release: got %0d want 0", sw_code); else n_pass++;
    n = 0; evt_ready = 1'b1;
    for (k = 0; k < 8 && evt_valid; k++) begin n++; cyc(); end
    evt_ready = 1'b0;
`ifdef SWITCH_RELEASE_EVT_EN
    n_total++; if (n !== 2) $display("FAIL ch6_events: got %0d want 2", n); else n_pass++;
`else
    n_total++; if (n !== 1) $display("FAIL ch6_events: got %0d want 1", n); else n_pass++;
`endif
  endtask

  task automatic test_random();
    do_reset(7'h00);
    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) begin
        rst_n = 1'b0; model_reset(); #1;
        n_total++; if (sw_state !== 7'h00 || evt_valid !== 1'b0 || ovf !== 1'b0 || sw_code !== 3'd0)
          $display("FAIL rnd_midreset: got s=%h v=%b o=%b c=%0d want all 0", sw_state, evt_valid, ovf, sw_code);
        else n_pass++;
        cyc(); cyc(); rst_n = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) sw_in = N_CH'($urandom);
      else if ($urandom_range(0, 29) == 0) sw_in = sw_in ^ N_CH'(1 << $urandom_range(0, N_CH - 1));
      evt_ready = (k < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      cyc();
      n_total++; if (sw_state !== m_state_vec()) $display("FAIL rnd_state@%0d: got %h want %h", k, sw_state, m_state_vec()); else n_pass++;
      n_total++; if (sw_code !== CODE_W'(m_code)) $display("FAIL rnd_code@%0d: got %0d want %0d", k, sw_code, m_code); else n_pass++;
      n_total++; if (evt_valid !== (m_q.size() > 0)) $display("FAIL rnd_valid@%0d: got %b want %b", k, evt_valid, m_q.size() > 0); else n_pass++;
      n_total++; if (evt_data !== m_head()) $display("FAIL rnd_data@%0d: got %h want %h", k, evt_data, m_head()); else n_pass++;
      n_total++; if (ovf !== m_ovf) $display("FAIL rnd_ovf@%0d: got %b want %b", k, ovf, m_ovf); else n_pass++;
    end
    evt_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; sw_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_glitch();
    test_press_release();
    test_simultaneous();
    test_full_push_pop();
    test_release_ch6();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
